// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA priority arbiter.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    SERVICE,
    RELEASE
  } dma_state_e;

  // First requesting channel found when scanning upward (with wrap) from top.
  function automatic ch_idx_t pick_winner(input logic [NUM_CH-1:0] req, input ch_idx_t top);
    ch_idx_t idx;
    ch_idx_t win;
    logic    found;
    win   = top;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = top + ch_idx_t'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // DACK pattern at the requested polarity; active=0 gives all-inactive.
  function automatic logic [NUM_CH-1:0] dack_encode(input logic active, input ch_idx_t ch,
                                                    input logic sense_high);
    logic [NUM_CH-1:0] onehot;
    onehot = '0;
    if (active) onehot[ch] = 1'b1;
    return sense_high ? onehot : ~onehot;
  endfunction

endpackage

// File: rtl/dma_dreq_sync.sv
// Two-flop synchronizer for the asynchronous DREQ lines.
module dma_dreq_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Both stages clear on synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dma_priority.sv
// DMA channel priority arbiter and bus hold/acknowledge sequencer.
// Optional feature: define DMA_SWREQ_EN to add the sw_req software request input.
module dma_priority
  import dma_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] mask,
  input  logic              rotate_pri,
  input  logic              dreq_sense_low,
  input  logic              dack_sense_high,
  input  logic              xfer_done,
`ifdef DMA_SWREQ_EN
  input  logic [NUM_CH-1:0] sw_req,
`endif
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        active_ch,
  output logic              svc_valid
);

  logic [NUM_CH-1:0] dreq_sync;
  logic [NUM_CH-1:0] req_hw;
  logic [NUM_CH-1:0] qual;
  ch_idx_t           top_pri;
  ch_idx_t           winner;

  dma_state_e        state_q;
  logic              hrq_q;
  logic [NUM_CH-1:0] dack_q;
  logic              svc_q;
  ch_idx_t           ch_q;
  ch_idx_t           ptr_q;

  dma_dreq_sync #(
    .Width (NUM_CH)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (DREQ),
    .q_o   (dreq_sync)
  );

  // Sense-corrected, masked request vector and arbitration winner.
  always_comb begin
    req_hw = (dreq_sync ^ {NUM_CH{dreq_sense_low}}) & ~mask;
`ifdef DMA_SWREQ_EN
    qual = req_hw | sw_req;
`else
    qual = req_hw;
`endif
    top_pri = rotate_pri ? ptr_q : ch_idx_t'(0);
    winner  = pick_winner(qual, top_pri);
  end

  // Sequencer with all outputs registered; arbitration only on HOLD_REQ -> SERVICE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= dack_encode(1'b0, ch_idx_t'(0), dack_sense_high);
      svc_q   <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      dack_q <= dack_encode(1'b0, ch_q, dack_sense_high);
      unique case (state_q)
        IDLE: begin
          if (|qual) begin
            state_q <= HOLD_REQ;
            hrq_q   <= 1'b1;
          end
        end
        HOLD_REQ: begin
          if (HLDA) begin
            if (|qual) begin
              state_q <= SERVICE;
              ch_q    <= winner;
              svc_q   <= 1'b1;
              dack_q  <= dack_encode(1'b1, winner, dack_sense_high);
            end else begin
              state_q <= RELEASE;
              hrq_q   <= 1'b0;
            end
          end
        end
        SERVICE: begin
          // Losing HLDA is treated the same as end of transfer.
          if (xfer_done || !HLDA) begin
            state_q <= RELEASE;
            hrq_q   <= 1'b0;
            svc_q   <= 1'b0;
            if (rotate_pri) ptr_q <= ch_q + ch_idx_t'(1);
          end else begin
            dack_q <= dack_encode(1'b1, ch_q, dack_sense_high);
          end
        end
        RELEASE: begin
          if (!HLDA) state_q <= IDLE;
        end
      endcase
    end
  end

  assign HRQ       = hrq_q;
  assign DACK      = dack_q;
  assign active_ch = ch_q;
  assign svc_valid = svc_q;

endmodule

// File: tb/tb_dma_priority.sv
// Directed self-checking bench for dma_priority.
module tb_dma_priority;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] mask;
  logic       rotate_pri;
  logic       dreq_sense_low;
  logic       dack_sense_high;
  logic       xfer_done;
`ifdef DMA_SWREQ_EN
  logic [3:0] sw_req;
`endif
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] active_ch;
  logic       svc_valid;

  int n_checks;
  int n_errors;

  dma_priority u_dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .DREQ            (DREQ),
    .HLDA            (HLDA),
    .mask            (mask),
    .rotate_pri      (rotate_pri),
    .dreq_sense_low  (dreq_sense_low),
    .dack_sense_high (dack_sense_high),
    .xfer_done       (xfer_done),
`ifdef DMA_SWREQ_EN
    .sw_req          (sw_req),
`endif
    .HRQ             (HRQ),
    .DACK            (DACK),
    .active_ch       (active_ch),
    .svc_valid       (svc_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic wait_hrq(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (HRQ === 1'b1) break;
      tick();
    end
    check({tag, "_hrq"}, 32'(HRQ), 32'd1);
  endtask

  // Wait for HRQ, grant the bus, and check the latched channel.
  task automatic start_service(input string tag, input logic [1:0] exp_ch,
                               input logic [3:0] exp_dack);
    wait_hrq(tag);
    HLDA = 1'b1;
    tick();
    check({tag, "_svc"}, 32'(svc_valid), 32'd1);
    check({tag, "_ch"}, 32'(active_ch), 32'(exp_ch));
    check({tag, "_dack"}, 32'(DACK), 32'(exp_dack));
  endtask

  // Pulse xfer_done, check the release cycle, then drop HLDA back to IDLE.
  task automatic end_service(input string tag, input logic [3:0] idle_dack);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check({tag, "_rel_hrq"}, 32'(HRQ), 32'd0);
    check({tag, "_rel_svc"}, 32'(svc_valid), 32'd0);
    check({tag, "_rel_dack"}, 32'(DACK), 32'(idle_dack));
    HLDA = 1'b0;
    tick();
  endtask

  logic [3:0] rot_dack [4];

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rot_dack        = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    RESET           = 1'b1;
    DREQ            = 4'b0000;
    HLDA            = 1'b0;
    mask            = 4'b0000;
    rotate_pri      = 1'b0;
    dreq_sense_low  = 1'b0;
    dack_sense_high = 1'b0;
    xfer_done       = 1'b0;
`ifdef DMA_SWREQ_EN
    sw_req          = 4'b0000;
`endif
    tick(2);
    check("rst_hrq", 32'(HRQ), 32'd0);
    check("rst_dack", 32'(DACK), 32'hf);
    check("rst_svc", 32'(svc_valid), 32'd0);
    check("rst_ch", 32'(active_ch), 32'd0);

    // Fixed priority, DREQ=0110; earliest HRQ is 3 edges after reset release.
    RESET = 1'b0;
    DREQ  = 4'b0110;
    tick(2);
    check("fix_hrq_early", 32'(HRQ), 32'd0);
    tick();
    check("fix_hrq_3cyc", 32'(HRQ), 32'd1);
    xfer_done = 1'b1;  // must be ignored outside SERVICE
    tick();
    xfer_done = 1'b0;
    tick();
    check("fix_hrq_hold", 32'(HRQ), 32'd1);
    check("fix_no_svc", 32'(svc_valid), 32'd0);
    start_service("fix", 2'd1, 4'b1101);
    DREQ = 4'b0001;  // higher priority arrives: no pre-emption
    tick(3);
    check("fix_nopreempt_ch", 32'(active_ch), 32'd1);
    check("fix_nopreempt_dack", 32'(DACK), 32'hd);
    check("fix_nopreempt_svc", 32'(svc_valid), 32'd1);
    DREQ = 4'b0000;
    end_service("fix", 4'b1111);
    tick(3);

    // Rotating priority with all channels requesting.
    rotate_pri = 1'b1;
    DREQ       = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      start_service("rot", 2'(i), rot_dack[i]);
      end_service("rot", 4'b1111);
    end
    DREQ       = 4'b0000;
    rotate_pri = 1'b0;
    tick(3);

    // Active-low DREQ, active-high DACK.
    mask            = 4'b1111;
    dreq_sense_low  = 1'b1;
    dack_sense_high = 1'b1;
    DREQ            = 4'b1011;
    tick(3);
    check("sense_idle_dack", 32'(DACK), 32'h0);
    mask = 4'b0000;
    start_service("sense", 2'd2, 4'b0100);
    DREQ = 4'b1111;
    end_service("sense", 4'b0000);
    mask            = 4'b1111;
    dreq_sense_low  = 1'b0;
    dack_sense_high = 1'b0;
    DREQ            = 4'b0000;
    tick(3);
    mask = 4'b0000;
    tick();
    check("sense_restore_dack", 32'(DACK), 32'hf);
    check("sense_restore_hrq", 32'(HRQ), 32'd0);

    // Request vanishes before HLDA: HOLD_REQ -> RELEASE with no service.
    mask = 4'b1110;
    DREQ = 4'b0001;
    tick();
    DREQ = 4'b0000;
    wait_hrq("drop");
    HLDA = 1'b1;
    tick();
    check("drop_hrq", 32'(HRQ), 32'd0);
    check("drop_svc", 32'(svc_valid), 32'd0);
    check("drop_dack", 32'(DACK), 32'hf);
    HLDA = 1'b0;
    tick();
    check("drop_idle_hrq", 32'(HRQ), 32'd0);
    check("drop_idle_dack", 32'(DACK), 32'hf);
    tick(2);
    check("drop_stay_idle", 32'(HRQ), 32'd0);
    mask = 4'b0000;

    // Reset mid-service must also clear the rotation pointer.
    rotate_pri = 1'b1;
    DREQ       = 4'b0010;
    start_service("rst1", 2'd1, 4'b1101);
    DREQ = 4'b0000;
    end_service("rst1", 4'b1111);
    tick(3);
    DREQ = 4'b0100;
    start_service("rst2", 2'd2, 4'b1011);
    RESET = 1'b1;
    HLDA  = 1'b0;
    tick();
    check("midrst_hrq", 32'(HRQ), 32'd0);
    check("midrst_dack", 32'(DACK), 32'hf);
    check("midrst_svc", 32'(svc_valid), 32'd0);
    check("midrst_ch", 32'(active_ch), 32'd0);
    RESET = 1'b0;
    DREQ  = 4'b1111;
    start_service("ptr0", 2'd0, 4'b1110);
    DREQ = 4'b0000;
    end_service("ptr0", 4'b1111);
    rotate_pri = 1'b0;
    tick(3);

`ifdef DMA_SWREQ_EN
    // Software request bypasses the mask.
    mask   = 4'b1111;
    sw_req = 4'b1000;
    start_service("swreq", 2'd3, 4'b0111);
    sw_req = 4'b0000;
    end_service("swreq", 4'b1111);
    mask = 4'b0000;
    tick(2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_priority.md
DMA_PRIORITY -- requirements
Module: dma_priority

Interface
- REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
  - CLK: input, 1 bit, single clock.
  - RESET: input, 1 bit, synchronous, active-high.
- REQ-002 The block SHALL have these ports:
  - DREQ: input, 4 bits, asynchronous channel requests.
  - HLDA: input, 1 bit, CPU hold acknowledge.
  - mask: input, 4 bits, channel mask; 1 = channel disabled.
  - rotate_pri: input, 1 bit; 0 = fixed priority, 1 = rotating priority.
  - dreq_sense_low: input, 1 bit; 1 = DREQ active-low.
  - dack_sense_high: input, 1 bit; 1 = DACK active-high.
  - xfer_done: input, 1 bit, one-cycle pulse from timing control at end of service (TC or EOP).
  - HRQ: output, 1 bit, hold request to CPU.
  - DACK: output, 4 bits, per-channel acknowledge, polarity set by dack_sense_high.
  - active_ch: output, 2 bits, channel in service.
  - svc_valid: output, 1 bit, high while a channel is in service.

Function
- REQ-003 DREQ SHALL pass through a 2-flop synchronizer, then be XORed with dreq_sense_low to form active-high requests.
- REQ-004 A channel request SHALL qualify when its synchronized request is 1 and its mask bit is 0.
- REQ-005 The FSM SHALL have states IDLE, HOLD_REQ, SERVICE and RELEASE; all outputs SHALL be registered.
- REQ-006 IDLE: any qualified request SHALL cause entry to HOLD_REQ on the next edge, with HRQ=1 from that cycle.
- REQ-007 HOLD_REQ: HRQ SHALL stay 1 until HLDA=1 is sampled.
- REQ-008 On the edge where HLDA=1 is sampled in HOLD_REQ:
  - if a qualified request exists, the winner SHALL be latched into active_ch and the FSM SHALL enter SERVICE;
  - otherwise the FSM SHALL enter RELEASE.
- REQ-009 SERVICE: svc_valid SHALL be 1 and DACK[active_ch] SHALL be at its active level; all other DACK bits SHALL be inactive.
- REQ-010 Arbitration SHALL be performed only at the HOLD_REQ-to-SERVICE transition; new or higher-priority requests during SERVICE SHALL NOT pre-empt.
- REQ-011 Masking or deasserting the active channel during SERVICE SHALL NOT end service; only xfer_done, or HLDA falling, SHALL end it.
- REQ-012 xfer_done=1 in SERVICE SHALL cause entry to RELEASE on the next edge; in that cycle HRQ=0, DACK all inactive, svc_valid=0.
- REQ-013 HLDA=0 sampled in SERVICE (CPU revokes the bus) SHALL be treated as xfer_done.
- REQ-014 RELEASE: HRQ SHALL stay 0 until HLDA=0 is sampled, then the FSM SHALL return to IDLE; a new request is considered from IDLE only, so at least one IDLE cycle separates services.
- REQ-015 Fixed priority: channel 0 highest, channel 3 lowest.
- REQ-016 Rotating priority:
  - a 2-bit pointer SHALL hold the highest-priority channel;
  - on leaving SERVICE, the pointer SHALL become (active_ch+1) mod 4, so the serviced channel becomes lowest priority;
  - the pointer SHALL update only when rotate_pri=1.
- REQ-017 xfer_done outside SERVICE SHALL be ignored.
- REQ-018 The DACK inactive level SHALL be ~dack_sense_high on all bits, in every state including reset.

Reset
- REQ-019 RESET=1 at any clock edge, including mid-service, SHALL force:
  - state IDLE, HRQ=0, DACK inactive, svc_valid=0, active_ch=0;
  - rotation pointer 0;
  - synchronizer flops 0.
- REQ-020 The first arbitration SHALL be possible no earlier than 3 cycles after RESET deasserts (2 synchronizer cycles + IDLE).

Configuration
- REQ-021 With DMA_SWREQ_EN defined:
  - the block SHALL add input sw_req (4 bits, software request register);
  - sw_req bits SHALL be ORed with the synchronized requests after sense correction;
  - sw_req SHALL be unaffected by mask;
  - the serviced channel's sw_req bit is cleared externally on xfer_done.
- REQ-022 Without DMA_SWREQ_EN, the sw_req port SHALL be absent and only hardware DREQ SHALL be arbitrated.

Structure
- REQ-023 Package dma_pkg SHALL hold:
  - the state enum (IDLE, HOLD_REQ, SERVICE, RELEASE);
  - NUM_CH=4;
  - the channel-index typedef (2 bits).
- REQ-024 Sub-module dma_dreq_sync SHALL implement the 4-bit 2-flop synchronizer; arbitration and the FSM stay in dma_priority.

Verification
- REQ-025 The bench SHALL cover these directed scenarios:
  - Fixed, sense defaults, DREQ=4'b0110, HLDA returned 2 cycles after HRQ -> active_ch=1, DACK=4'b1101, svc_valid=1 until xfer_done.
  - Rotating, DREQ=4'b1111 held, 4 services -> channel order 0,1,2,3.
  - dreq_sense_low=1, DREQ=4'b1011, mask=4'b0000, dack_sense_high=1 -> active_ch=2, DACK=4'b0100.
  - DREQ[0] pulses and drops before HLDA, mask=4'b1110 -> FSM goes HOLD_REQ->RELEASE, DACK never active, HRQ drops.
  - RESET asserted mid-SERVICE -> next cycle HRQ=0, DACK=4'b1111, svc_valid=0, pointer=0.
  - DMA_SWREQ_EN defined, sw_req=4'b1000, mask=4'b1111, DREQ=0 -> channel 3 serviced.
